branch_hazard_ctrl: RTL and testbench
=====================================

# branch_hazard_ctrl

Stall, flush and forward-select controller for branches resolved in the ID stage of the 5-stage MIPS pipeline. It detects operand hazards between a branch in ID and older instructions in EX and MEM. It stalls PC and IF/ID, injects bubbles into ID/EX, selects the comparator forwarding source, and flushes IF/ID on a taken branch. A two-state FSM sequences the two-cycle load-to-branch stall, and saturating counters record stall and flush activity.

## Interface
Parameters:
- CNT_W, 16, width of the perf counters (saturating)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; returns FSM to RUN and clears counters
- ID_Branch  input  1  instruction in ID is beq/bne
- ID_Rs, ID_Rt  input  5  source registers of the branch in ID
- Branch_Taken  input  1  ID comparator result, already using forwarded operands
- EX_RegWrite, EX_MemRead  input  1  control bits of the instruction in EX
- EX_Rd  input  5  destination register of the instruction in EX
- MEM_RegWrite, MEM_MemRead  input  1  control bits of the instruction in MEM
- MEM_Rd  input  5  destination register of the instruction in MEM
- Perf_Clear  input  1  synchronous clear of both counters
- PCWrite  output  1  0 = hold PC
- IFID_Write  output  1  0 = hold IF/ID
- IDEX_Bubble  output  1  1 = zero ID/EX control bits
- IFID_Flush  output  1  1 = load a nop into IF/ID
- ForwardA, ForwardB  output  2  comparator operand select for Rs/Rt: 00 = regfile, 01 = EX ALU result, 10 = EX/MEM ALU result
- Stall_Count, Flush_Count  output  CNT_W  perf counters

## Operation
Match definitions:
- mE(r) = (EX_Rd != 0) & (EX_Rd == r)
- mM(r) = (MEM_Rd != 0) & (MEM_Rd == r)
- r is ID_Rs or ID_Rt.

Hazard classes (all qualified by ID_Branch):
- LD1: EX_MemRead & (mE(Rs) | mE(Rt)). Needs 2 stall cycles.
- LD2: MEM_MemRead & (mM(Rs) | mM(Rt)). Needs 1 stall cycle.
- No stall for ALU producers. ForwardA = 01 if EX_RegWrite & !EX_MemRead & mE(Rs). Otherwise ForwardA = 10 if MEM_RegWrite & !MEM_MemRead & mM(Rs). Otherwise 00. ForwardB is the same with Rt. EX has priority over MEM.

FSM states:
- RUN:
  - If LD1: stall this cycle and go to HOLD.
  - Else if LD2: stall this cycle and stay in RUN.
  - Else no stall, stay in RUN.
- HOLD:
  - Stall unconditionally (the load is now in MEM), then go to RUN.
  - LD2 is not re-evaluated in HOLD.

Stall cycle outputs:
- PCWrite = 0, IFID_Write = 0, IDEX_Bubble = 1.
- ForwardA/B are driven but don't-care.
- IFID_Flush = 0. Stall beats flush: the branch is not resolved while stalled.

Flush:
- IFID_Flush = ID_Branch & Branch_Taken & no stall this cycle.
- IFID_Write stays 1 during a flush.

Counters:
- Stall_Count increments each stall cycle.
- Flush_Count increments each cycle IFID_Flush = 1.
- Both saturate at all-ones.
- Perf_Clear has priority over increment.

Non-branch in ID (ID_Branch = 0) in RUN:
- No stall, no flush, ForwardA/B = 00.
- Load-use for ALU consumers is handled elsewhere.

## Timing
- Reset values: state RUN, PCWrite = 1, IFID_Write = 1, IDEX_Bubble = 0, IFID_Flush = 0, ForwardA/B = 00, counters 0.
- State register and counters update on the rising edge of clk. Reset is asynchronous.
- All outputs except the counters are combinational from state and current inputs (Mealy), valid in the same cycle.
- LD1 latency: stall in cycles N and N+1. The branch resolves in N+2 with the load in WB; the regfile is write-before-read, so ForwardA/B = 00.
- LD2 latency: stall in cycle N, resolve in N+1.
- Reset asserted in HOLD: return to RUN immediately and deassert the stall asynchronously.
- LD1 and LD2 both true: LD1 wins and goes to HOLD.
- Perf_Clear together with a stall or flush: counter reads 0 next cycle.

## Test plan
- Reset pulse mid-HOLD -> PCWrite = 1, IFID_Write = 1, IDEX_Bubble = 0 within the same cycle; state RUN; counters 0.
- lw $t0, then beq $t0,$t1 in ID (EX_MemRead = 1, EX_Rd = 8, ID_Rs = 8) -> exactly 2 stall cycles; Stall_Count = 2; third cycle ForwardA = 00, IFID_Flush = Branch_Taken.
- add $t2 in EX, beq $t3,$t2 in ID (EX_RegWrite = 1, EX_Rd = 10, ID_Rt = 10) -> no stall, ForwardB = 01. Same producer in MEM instead -> ForwardB = 10. Both EX and MEM write $t2 -> ForwardB = 01.
- Producer writes $zero (EX_Rd = 0, EX_MemRead = 1, ID_Rs = 0) -> no stall, ForwardA = 00.
- Taken beq, no hazards (Branch_Taken = 1) -> IFID_Flush = 1 for one cycle; Flush_Count += 1. LD2 with Branch_Taken = 1 -> first cycle stall with flush 0, next cycle flush 1.
- Preload Stall_Count = 0xFFFE, force 3 stall cycles -> reads 0xFFFF. Perf_Clear coincident with a stall -> reads 0.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
//   Hazard controller for branches resolved in the ID stage of a 5-stage
//   MIPS pipeline. It detects operand hazards between the branch in ID and
//   older instructions in EX and MEM. It then stalls, forwards or flushes.
//   It also keeps saturating counts of stall and flush cycles.
//
// Ports
//   clk, reset                   clock (rising edge), async active-high reset
//   ID_Branch, ID_Rs, ID_Rt      branch in ID and its source registers
//   Branch_Taken                 ID comparator result
//   EX_RegWrite/MemRead/Rd       instruction in EX
//   MEM_RegWrite/MemRead/Rd      instruction in MEM
//   Perf_Clear                   synchronous clear of both counters
//   PCWrite, IFID_Write          0 = hold PC / IF/ID
//   IDEX_Bubble                  1 = zero ID/EX control bits
//   IFID_Flush                   1 = load a nop into IF/ID
//   ForwardA, ForwardB           00 regfile, 01 EX result, 10 EX/MEM result
//   Stall_Count, Flush_Count     saturating perf counters
module branch_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_Branch,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             Branch_Taken,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_Rd,
  input  logic             Perf_Clear,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] stall_count_reg, flush_count_reg;

  // Register matches. Register $zero never creates a dependency.
  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic ld1, ld2, stall, flush;

  assign ex_rs  = (EX_Rd  != 5'd0) && (EX_Rd  == ID_Rs);
  assign ex_rt  = (EX_Rd  != 5'd0) && (EX_Rd  == ID_Rt);
  assign mem_rs = (MEM_Rd != 5'd0) && (MEM_Rd == ID_Rs);
  assign mem_rt = (MEM_Rd != 5'd0) && (MEM_Rd == ID_Rt);

  assign ld1 = ID_Branch && EX_MemRead  && (ex_rs  || ex_rt);
  assign ld2 = ID_Branch && MEM_MemRead && (mem_rs || mem_rt);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. LD1 takes precedence over LD2 because it needs the
  // extra HOLD cycle.
  always_comb begin
    state_next = RUN;
    case (state_reg)
      RUN:     state_next = ld1 ? HOLD : RUN;
      HOLD:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Output logic (Mealy). In HOLD the load has moved to MEM. The stall is
  // unconditional there, so LD2 is not looked at again.
  always_comb begin
    stall = 1'b0;
    case (state_reg)
      RUN:     stall = ld1 || ld2;
      HOLD:    stall = 1'b1;
      default: stall = 1'b0;
    endcase

    // The branch is not resolved while it is stalled, so a stall suppresses the flush.
    flush       = ID_Branch && Branch_Taken && !stall;
    PCWrite     = !stall;
    IFID_Write  = !stall;
    IDEX_Bubble = stall;
    IFID_Flush  = flush;

    // Only ALU producers are forwarded. EX is checked first because it holds the youngest value.
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (ID_Branch) begin
      if (EX_RegWrite && !EX_MemRead && ex_rs)
        ForwardA = 2'b01;
      else if (MEM_RegWrite && !MEM_MemRead && mem_rs)
        ForwardA = 2'b10;
      if (EX_RegWrite && !EX_MemRead && ex_rt)
        ForwardB = 2'b01;
      else if (MEM_RegWrite && !MEM_MemRead && mem_rt)
        ForwardB = 2'b10;
    end
  end

  // Saturating perf counters. A clear takes priority over an increment.
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else if (Perf_Clear) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (stall && !(&stall_count_reg))
        stall_count_reg <= stall_count_reg + ONE;
      if (flush && !(&flush_count_reg))
        flush_count_reg <= flush_count_reg + ONE;
    end
  end

  assign Stall_Count = stall_count_reg;
  assign Flush_Count = flush_count_reg;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Testbench for branch_hazard_ctrl. It runs directed scenarios and then
// randomized traffic. A scoreboard queue holds the expected outputs, and a
// negedge monitor compares them against the DUT.
module tb_branch_hazard_ctrl;

  localparam int CNT_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             ID_Branch, Branch_Taken;
  logic [4:0]       ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
  logic             EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead;
  logic             Perf_Clear;
  logic             PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush;
  logic [1:0]       ForwardA, ForwardB;
  logic [CNT_W-1:0] Stall_Count, Flush_Count;

  branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ID_Branch(ID_Branch), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .Branch_Taken(Branch_Taken),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd),
    .Perf_Clear(Perf_Clear),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
    .IFID_Flush(IFID_Flush), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  id;
    bit  stall;
    bit  flush;
    int  fa, fb;
    int  sc, fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model state.
  int   stalls_left = 0;   // stall cycles still owed to an earlier load
  int   m_sc = 0, m_fc = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int fwd_sel(input logic [4:0] r);
    // Use the youngest ALU producer of r. Loads and $zero give no forward.
    if (!ID_Branch) return 0;
    if (EX_RegWrite && !EX_MemRead && EX_Rd != 0 && EX_Rd == r) return 1;
    if (MEM_RegWrite && !MEM_MemRead && MEM_Rd != 0 && MEM_Rd == r) return 2;
    return 0;
  endfunction

  function automatic bit dep(input logic [4:0] rd);
    return rd != 0 && (rd == ID_Rs || rd == ID_Rt);
  endfunction

  // Predict this cycle's outputs and queue them, advance the model, then
  // move to the next cycle. The inputs must already be driven.
  task automatic step();
    exp_t e;
    bit   ld1, ld2;
    ld1 = ID_Branch && EX_MemRead && dep(EX_Rd);
    ld2 = ID_Branch && MEM_MemRead && dep(MEM_Rd);
    e.id    = txn++;
    e.stall = (stalls_left > 0) || ld1 || ld2;
    e.flush = ID_Branch && Branch_Taken && !e.stall;
    e.fa    = fwd_sel(ID_Rs);
    e.fb    = fwd_sel(ID_Rt);
    e.sc    = m_sc;
    e.fc    = m_fc;
    sb.push_back(e);
    if (stalls_left > 0) stalls_left--;
    else if (ld1)        stalls_left = 1;
    if (Perf_Clear) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (e.stall && m_sc < CMAX) m_sc++;
      if (e.flush && m_fc < CMAX) m_fc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ID_Branch = 0; Branch_Taken = 0; ID_Rs = 0; ID_Rt = 0;
    EX_RegWrite = 0; EX_MemRead = 0; EX_Rd = 0;
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_Rd = 0; Perf_Clear = 0;
  endtask

  // Monitor: every cycle that has a queued expectation is compared at the
  // negedge, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("PCWrite",     int'(PCWrite),     int'(!e.stall));
      chk("IFID_Write",  int'(IFID_Write),  int'(!e.stall));
      chk("IDEX_Bubble", int'(IDEX_Bubble), int'(e.stall));
      chk("IFID_Flush",  int'(IFID_Flush),  int'(e.flush));
      if (!e.stall) begin
        chk("ForwardA", int'(ForwardA), e.fa);
        chk("ForwardB", int'(ForwardB), e.fb);
      end
      chk("Stall_Count", int'(Stall_Count), e.sc);
      chk("Flush_Count", int'(Flush_Count), e.fc);
      $display("txn %0d: stall=%0b flush=%0b fa=%0d fb=%0d sc=%0d fc=%0d",
               e.id, IDEX_Bubble, IFID_Flush, ForwardA, ForwardB,
               Stall_Count, Flush_Count);
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    #1;
    chk("reset_PCWrite",     int'(PCWrite),     1);
    chk("reset_IFID_Write",  int'(IFID_Write),  1);
    chk("reset_IDEX_Bubble", int'(IDEX_Bubble), 0);
    chk("reset_IFID_Flush",  int'(IFID_Flush),  0);
    chk("reset_Stall_Count", int'(Stall_Count), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // lw $t0; beq $t0,$t1. This gives two stalls, then the branch resolves with no forward.
    ID_Branch = 1; Branch_Taken = 1; ID_Rs = 8; ID_Rt = 9;
    EX_RegWrite = 1; EX_MemRead = 1; EX_Rd = 8;
    step();
    EX_RegWrite = 0; EX_MemRead = 0; EX_Rd = 0;
    MEM_RegWrite = 1; MEM_MemRead = 1; MEM_Rd = 8;
    step();
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_Rd = 0;
    step();

    // ALU producer of $t2 in EX, then in MEM, then in both stages.
    idle(); ID_Branch = 1; ID_Rs = 11; ID_Rt = 10;
    EX_RegWrite = 1; EX_Rd = 10; step();
    EX_RegWrite = 0; EX_Rd = 0; MEM_RegWrite = 1; MEM_Rd = 10; step();
    EX_RegWrite = 1; EX_Rd = 10; step();

    // A load that writes $zero creates no hazard.
    idle(); ID_Branch = 1; ID_Rs = 0; EX_RegWrite = 1; EX_MemRead = 1; step();

    // Taken branch with no hazard, then LD2 with taken.
    idle(); ID_Branch = 1; Branch_Taken = 1; ID_Rs = 3; ID_Rt = 4; step();
    MEM_RegWrite = 1; MEM_MemRead = 1; MEM_Rd = 4; step();
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_Rd = 0; step();

    // LD1 and LD2 together: LD1 wins and the controller enters HOLD.
    idle(); ID_Branch = 1; ID_Rs = 5; ID_Rt = 6;
    EX_MemRead = 1; EX_Rd = 5; MEM_MemRead = 1; MEM_Rd = 6; step();
    idle(); step();

    // Perf_Clear coincident with a stall.
    idle(); ID_Branch = 1; ID_Rs = 7; MEM_MemRead = 1; MEM_Rd = 7; Perf_Clear = 1;
    step();
    idle(); step();

    // Async reset while in HOLD.
    ID_Branch = 1; ID_Rs = 2; EX_MemRead = 1; EX_Rd = 2; step();
    idle();
    #1;
    chk("hold_PCWrite", int'(PCWrite), 0);
    #1 reset = 1'b1;
    #1;
    chk("hold_rst_PCWrite",     int'(PCWrite),     1);
    chk("hold_rst_IFID_Write",  int'(IFID_Write),  1);
    chk("hold_rst_IDEX_Bubble", int'(IDEX_Bubble), 0);
    chk("hold_rst_Stall_Count", int'(Stall_Count), 0);
    chk("hold_rst_Flush_Count", int'(Flush_Count), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    stalls_left = 0; m_sc = 0; m_fc = 0;

    // Randomized traffic uses a small register pool so that matches are frequent.
    // It saturates the small counters and clears them now and then.
    for (int i = 0; i < 800; i++) begin
      ID_Branch    = ($urandom_range(3) != 0);
      Branch_Taken = $urandom_range(1);
      ID_Rs        = 5'($urandom_range(3));
      ID_Rt        = 5'($urandom_range(3));
      EX_RegWrite  = $urandom_range(1);
      EX_MemRead   = ($urandom_range(2) == 0);
      EX_Rd        = 5'($urandom_range(3));
      MEM_RegWrite = $urandom_range(1);
      MEM_MemRead  = ($urandom_range(2) == 0);
      MEM_Rd       = 5'($urandom_range(3));
      Perf_Clear   = ($urandom_range(99) == 0);
      step();
    end
    idle();

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
